// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control types: FSM state encoding, stall/flush cause priority
// and the control-word patterns that the hazard and forwarding units also decode.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HAZ_STALL = 2'd1,
    MEM_WAIT  = 2'd2
  } state_e;

  // Highest-priority request active this cycle; CAUSE_NONE means free-running.
  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_FREEZE = 3'd1,
    CAUSE_BRANCH = 3'd2,
    CAUSE_HAZARD = 3'd3,
    CAUSE_FETCH  = 3'd4
  } cause_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = 7'b0010101;
  localparam ctrl_t CTRL_IDLE   = 7'b1101010;
  localparam ctrl_t CTRL_FREEZE = 7'b0000001;
  localparam ctrl_t CTRL_BRANCH = 7'b1111110;
  localparam ctrl_t CTRL_HAZARD = 7'b0001110;
  localparam ctrl_t CTRL_FETCH  = 7'b0111010;

  function automatic cause_e decode_cause(input logic mem_freeze,
                                          input logic branch_taken,
                                          input logic hazard,
                                          input logic imem_ready);
    cause_e c;
    c = CAUSE_NONE;
    if (mem_freeze)       c = CAUSE_FREEZE;
    else if (branch_taken) c = CAUSE_BRANCH;
    else if (hazard)       c = CAUSE_HAZARD;
    else if (!imem_ready)  c = CAUSE_FETCH;
    return c;
  endfunction

  function automatic ctrl_t cause_ctrl(input cause_e c);
    ctrl_t w;
    w = CTRL_IDLE;
    case (c)
      CAUSE_FREEZE: w = CTRL_FREEZE;
      CAUSE_BRANCH: w = CTRL_BRANCH;
      CAUSE_HAZARD: w = CTRL_HAZARD;
      CAUSE_FETCH:  w = CTRL_FETCH;
      default:      w = CTRL_IDLE;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/control bundle between the pipeline stages (master) and the
// stall controller (slave), plus the controller's status and debug view.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_pkg::*;

  // Handshakes are level-sampled every cycle: imem_ready says fetch data is
  // valid now; a MEM access is outstanding while dmem_req=1 and completes in
  // the cycle dmem_ready=1. There is no skid: a stage holds its request until done.
  logic             hazard;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             mem_wb_flush;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             hazard_err;
  logic             mem_timeout;

  state_e           dbg_state;
  cause_e           dbg_cause;

  modport master (
    output hazard, branch_taken, imem_ready, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
    input  ex_mem_write, mem_wb_flush,
    input  stall_cnt, flush_cnt, hazard_err, mem_timeout,
    input  dbg_state, dbg_cause
  );

  modport slave (
    input  hazard, branch_taken, imem_ready, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
    output ex_mem_write, mem_wb_flush,
    output stall_cnt, flush_cnt, hazard_err, mem_timeout,
    output dbg_state, dbg_cause
  );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: combinational priority decode of the stage
// requests, plus an FSM that tracks hazard repeats and long MEM waits.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_stall_ctrl_if.slave bus
);

  // wait_cnt only needs to reach TIMEOUT-1; it saturates there.
  localparam int                WAIT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam bit                TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = TIMEOUT_EN ? WAIT_W'(TIMEOUT - 1) : '0;

  logic              w_mem_freeze;
  cause_e            w_cause;
  ctrl_t             w_ctrl;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_hazard_err_set;
  logic              w_timeout_set;
  logic              r_hazard_err;
  logic              r_mem_timeout;

  logic [WAIT_W-1:0] w_wait_cnt;
  logic [CNT_W-1:0]  w_stall_cnt;
  logic [CNT_W-1:0]  w_flush_cnt;
  logic              w_stall_inc;
  logic              w_flush_inc;

  assign w_mem_freeze = bus.dmem_req & ~bus.dmem_ready;
  assign w_cause      = decode_cause(w_mem_freeze, bus.branch_taken, bus.hazard, bus.imem_ready);

  // Reset forces every register to hold a bubble, independent of requests.
  always_comb begin
    w_ctrl = CTRL_RESET;
    if (rst_n) begin
      w_ctrl = cause_ctrl(w_cause);
    end
  end

  assign bus.pc_write     = w_ctrl.pc_write;
  assign bus.if_id_write  = w_ctrl.if_id_write;
  assign bus.if_id_flush  = w_ctrl.if_id_flush;
  assign bus.id_ex_write  = w_ctrl.id_ex_write;
  assign bus.id_ex_flush  = w_ctrl.id_ex_flush;
  assign bus.ex_mem_write = w_ctrl.ex_mem_write;
  assign bus.mem_wb_flush = w_ctrl.mem_wb_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_hazard_err_set = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_freeze) begin
          w_state_nxt = MEM_WAIT;
        end else if (bus.hazard && !bus.branch_taken) begin
          w_state_nxt = HAZ_STALL;
        end else begin
          w_state_nxt = RUN;
        end
      end
      HAZ_STALL: begin
        if (w_mem_freeze) begin
          w_state_nxt = MEM_WAIT;
        end else if (bus.hazard && !bus.branch_taken) begin
          // A load-use bubble should clear ID in one cycle; a repeat means the
          // hazard unit is stuck.
          w_hazard_err_set = 1'b1;
          w_state_nxt      = HAZ_STALL;
        end else begin
          w_state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (!w_mem_freeze) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // wait_cnt counts frozen cycles so far, so the flag sets on the edge that
  // closes the TIMEOUT-th consecutive frozen cycle.
  assign w_timeout_set = TIMEOUT_EN && w_mem_freeze && (w_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hazard_err  <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_hazard_err  <= r_hazard_err  | w_hazard_err_set;
      r_mem_timeout <= r_mem_timeout | w_timeout_set;
    end
  end

  assign w_stall_inc = ~w_ctrl.pc_write;
  assign w_flush_inc = (w_cause == CAUSE_BRANCH);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (w_stall_inc),
    .q     (w_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (w_flush_inc),
    .q     (w_flush_cnt)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~w_mem_freeze),
    .inc   (w_mem_freeze),
    .q     (w_wait_cnt)
  );

  assign bus.stall_cnt   = w_stall_cnt;
  assign bus.flush_cnt   = w_flush_cnt;
  assign bus.hazard_err  = r_hazard_err;
  assign bus.mem_timeout = r_mem_timeout;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_cause   = w_cause;

endmodule
